wb_commit_stage: RTL and testbench

//  Registered write-back/commit stage of the pipelined CPU; successor of the single-cycle combinational WB.

---
 rtl/wb_commit_stage_pkg.sv | 22 ++
 rtl/wb_commit_stage_load_ext.sv | 40 ++++
 rtl/wb_commit_stage.sv | 185 ++++++++++++++++++
 tb/tb_wb_commit_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared codes for the write-back/commit stage: result-select, load-size,
// halt encoding and FSM states.
package wb_commit_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_CSR  = 2'd2;
  localparam logic [1:0] WB_SEL_PC4  = 2'd3;

  localparam logic [1:0] LS_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] LS_SIZE_HALF  = 2'd1;
  localparam logic [1:0] LS_SIZE_WORD  = 2'd2;
  localparam logic [1:0] LS_SIZE_DWORD = 2'd3;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_commit_stage_load_ext.sv
// Combinational load-data extension: keeps the low byte/half/word/XLEN bits
// and sign- or zero-extends them back to XLEN.
module wb_load_ext #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] ext
);
  import wb_commit_stage_pkg::*;

  logic [XLEN-1:0] byte_ext;
  logic [XLEN-1:0] half_ext;
  logic [XLEN-1:0] word_ext;

  assign byte_ext = {{(XLEN-8){~uns & data[7]}}, data[7:0]};
  assign half_ext = {{(XLEN-16){~uns & data[15]}}, data[15:0]};

  // On a 32-bit datapath a word already fills the register, so no extension.
  generate
    if (XLEN > 32) begin : g_word_ext
      assign word_ext = {{(XLEN-32){~uns & data[31]}}, data[31:0]};
    end else begin : g_word_pass
      assign word_ext = data;
    end
  endgenerate

  always_comb begin
    ext = data;
    case (size)
      LS_SIZE_BYTE:  ext = byte_ext;
      LS_SIZE_HALF:  ext = half_ext;
      LS_SIZE_WORD:  ext = word_ext;
      LS_SIZE_DWORD: ext = data;
      default:       ext = data;
    endcase
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Registered write-back/commit stage: one-entry register fed from MEM,
// result select, regfile/forward drive, commit trace, retire count, EBREAK halt.
module wb_commit_stage #(
  parameter int              XLEN        = 64,
  parameter int              ILEN        = 32,
  parameter int              RAW         = 5,
  parameter int              CNT_W       = 64,
  parameter logic [ILEN-1:0] EBREAK_INST = ILEN'(wb_commit_stage_pkg::EBREAK_INST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_inst,
  input  logic             in_rd_ena,
  input  logic [RAW-1:0]   in_rd_addr,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_exu_res,
  input  logic [XLEN-1:0]  in_ls_data,
  input  logic [1:0]       in_ls_size,
  input  logic             in_ls_uns,
  input  logic [XLEN-1:0]  in_csr_data,
  input  logic             flush,
  output logic             wb_rd_ena,
  output logic [RAW-1:0]   wb_rd_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic             fwd_valid,
  output logic [RAW-1:0]   fwd_addr,
  output logic [XLEN-1:0]  fwd_data,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic [ILEN-1:0]  commit_inst,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halt,
  output logic [XLEN-1:0]  halt_pc
);
  import wb_commit_stage_pkg::*;

  wb_state_e       state_q, state_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic            rd_ena_q, rd_ena_d;
  logic [RAW-1:0]  rd_addr_q, rd_addr_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [XLEN-1:0] exu_res_q, exu_res_d;
  logic [XLEN-1:0] ls_data_q, ls_data_d;
  logic [1:0]      ls_size_q, ls_size_d;
  logic            ls_uns_q, ls_uns_d;
  logic [XLEN-1:0] csr_data_q, csr_data_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;

  logic            capture;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] sel_data;
  logic            rd_write;

  assign in_ready = (state_q == ST_RUN);
  assign capture  = in_valid & in_ready & ~flush;

  // Entry fields hold their last value when idle; only vld drops.
  always_comb begin
    vld_d      = capture;
    pc_d       = pc_q;
    inst_d     = inst_q;
    rd_ena_d   = rd_ena_q;
    rd_addr_d  = rd_addr_q;
    wb_sel_d   = wb_sel_q;
    exu_res_d  = exu_res_q;
    ls_data_d  = ls_data_q;
    ls_size_d  = ls_size_q;
    ls_uns_d   = ls_uns_q;
    csr_data_d = csr_data_q;
    if (capture) begin
      pc_d       = in_pc;
      inst_d     = in_inst;
      rd_ena_d   = in_rd_ena;
      rd_addr_d  = in_rd_addr;
      wb_sel_d   = in_wb_sel;
      exu_res_d  = in_exu_res;
      ls_data_d  = in_ls_data;
      ls_size_d  = in_ls_size;
      ls_uns_d   = in_ls_uns;
      csr_data_d = in_csr_data;
    end
  end

  // Halt is taken at capture so it shows alongside the EBREAK's own commit.
  always_comb begin
    state_d   = state_q;
    halt_pc_d = halt_pc_q;
    case (state_q)
      ST_RUN: begin
        if (capture && (in_inst == EBREAK_INST)) begin
          state_d   = ST_HALTED;
          halt_pc_d = in_pc;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (vld_q) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      vld_q        <= 1'b0;
      pc_q         <= '0;
      inst_q       <= '0;
      rd_ena_q     <= 1'b0;
      rd_addr_q    <= '0;
      wb_sel_q     <= '0;
      exu_res_q    <= '0;
      ls_data_q    <= '0;
      ls_size_q    <= '0;
      ls_uns_q     <= 1'b0;
      csr_data_q   <= '0;
      retire_cnt_q <= '0;
      halt_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      rd_ena_q     <= rd_ena_d;
      rd_addr_q    <= rd_addr_d;
      wb_sel_q     <= wb_sel_d;
      exu_res_q    <= exu_res_d;
      ls_data_q    <= ls_data_d;
      ls_size_q    <= ls_size_d;
      ls_uns_q     <= ls_uns_d;
      csr_data_q   <= csr_data_d;
      retire_cnt_q <= retire_cnt_d;
      halt_pc_q    <= halt_pc_d;
    end
  end

  wb_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .data (ls_data_q),
    .size (ls_size_q),
    .uns  (ls_uns_q),
    .ext  (load_ext)
  );

  always_comb begin
    sel_data = '0;
    if (vld_q) begin
      case (wb_sel_q)
        WB_SEL_ALU:  sel_data = exu_res_q;
        WB_SEL_LOAD: sel_data = load_ext;
        WB_SEL_CSR:  sel_data = csr_data_q;
        WB_SEL_PC4:  sel_data = pc_q + XLEN'(4);
        default:     sel_data = '0;
      endcase
    end
  end

  // Writes to x0 are dropped here, but the instruction still retires.
  assign rd_write     = vld_q & rd_ena_q & (rd_addr_q != '0);

  assign wb_rd_ena    = rd_write;
  assign wb_rd_addr   = rd_addr_q;
  assign wb_data      = sel_data;
  assign fwd_valid    = rd_write;
  assign fwd_addr     = rd_addr_q;
  assign fwd_data     = sel_data;
  assign commit_valid = vld_q;
  assign commit_pc    = pc_q;
  assign commit_inst  = inst_q;
  assign retire_cnt   = retire_cnt_q;
  assign halt         = (state_q == ST_HALTED);
  assign halt_pc      = halt_pc_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: drives transfers right after each edge,
// checks outputs one time unit after the edge that registered them.
module tb_wb_commit_stage;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int RAW   = 5;
  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [ILEN-1:0]  in_inst;
  logic             in_rd_ena;
  logic [RAW-1:0]   in_rd_addr;
  logic [1:0]       in_wb_sel;
  logic [XLEN-1:0]  in_exu_res;
  logic [XLEN-1:0]  in_ls_data;
  logic [1:0]       in_ls_size;
  logic             in_ls_uns;
  logic [XLEN-1:0]  in_csr_data;
  logic             flush;
  logic             wb_rd_ena;
  logic [RAW-1:0]   wb_rd_addr;
  logic [XLEN-1:0]  wb_data;
  logic             fwd_valid;
  logic [RAW-1:0]   fwd_addr;
  logic [XLEN-1:0]  fwd_data;
  logic             commit_valid;
  logic [XLEN-1:0]  commit_pc;
  logic [ILEN-1:0]  commit_inst;
  logic [CNT_W-1:0] retire_cnt;
  logic             halt;
  logic [XLEN-1:0]  halt_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_commit_stage #(
    .XLEN(XLEN), .ILEN(ILEN), .RAW(RAW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .in_rd_ena(in_rd_ena), .in_rd_addr(in_rd_addr),
    .in_wb_sel(in_wb_sel), .in_exu_res(in_exu_res),
    .in_ls_data(in_ls_data), .in_ls_size(in_ls_size), .in_ls_uns(in_ls_uns),
    .in_csr_data(in_csr_data), .flush(flush),
    .wb_rd_ena(wb_rd_ena), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .retire_cnt(retire_cnt), .halt(halt), .halt_pc(halt_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [31:0] inst, input logic rd_ena,
                       input logic [4:0] rd, input logic [1:0] sel, input logic [63:0] exu,
                       input logic [63:0] ls, input logic [1:0] size, input logic uns,
                       input logic [63:0] csr);
    in_valid    = 1'b1;
    flush       = 1'b0;
    in_pc       = pc;
    in_inst     = inst;
    in_rd_ena   = rd_ena;
    in_rd_addr  = rd;
    in_wb_sel   = sel;
    in_exu_res  = exu;
    in_ls_data  = ls;
    in_ls_size  = size;
    in_ls_uns   = uns;
    in_csr_data = csr;
    $display("txn pc=%h inst=%h rd=%0d sel=%0d size=%0d uns=%0d", pc, inst, rd, sel, size, uns);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".wb_rd_ena"}, 64'(wb_rd_ena), 64'd0);
    check({tag, ".wb_data"}, wb_data, 64'd0);
    check({tag, ".commit_valid"}, 64'(commit_valid), 64'd0);
    check({tag, ".commit_pc"}, commit_pc, 64'd0);
    check({tag, ".retire_cnt"}, retire_cnt, 64'd0);
    check({tag, ".halt"}, 64'(halt), 64'd0);
    check({tag, ".halt_pc"}, halt_pc, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  // Single load through the extender, checked in its commit cycle.
  task automatic load_case(input string tag, input logic [63:0] ls, input logic [1:0] size,
                           input logic uns, input logic [63:0] exp);
    drive(64'h8000_0100, 32'h0000_3003, 1'b1, 5'd6, 2'd1, 64'hDEAD, ls, size, uns, 64'h0);
    step();
    idle();
    check({tag, ".wb_data"}, wb_data, exp);
    check({tag, ".fwd_data"}, fwd_data, exp);
    step();
  endtask

  initial begin
    in_pc = '0; in_inst = '0; in_rd_ena = 1'b0; in_rd_addr = '0; in_wb_sel = '0;
    in_exu_res = '0; in_ls_data = '0; in_ls_size = '0; in_ls_uns = 1'b0; in_csr_data = '0;
    do_reset();
    check_all_zero("reset");

    // 1. ALU write
    drive(64'h8000_0000, 32'h0000_0013, 1'b1, 5'd5, 2'd0, 64'h1234, 64'h0, 2'd0, 1'b0, 64'h0);
    step();
    idle();
    check("alu.wb_rd_ena", 64'(wb_rd_ena), 64'd1);
    check("alu.wb_rd_addr", 64'(wb_rd_addr), 64'd5);
    check("alu.wb_data", wb_data, 64'h1234);
    check("alu.fwd_valid", 64'(fwd_valid), 64'd1);
    check("alu.fwd_addr", 64'(fwd_addr), 64'd5);
    check("alu.commit_valid", 64'(commit_valid), 64'd1);
    check("alu.commit_pc", commit_pc, 64'h8000_0000);
    check("alu.cnt_during", retire_cnt, 64'd0);
    step();
    check("alu.cnt_after", retire_cnt, 64'd1);
    check("alu.commit_done", 64'(commit_valid), 64'd0);
    check("alu.wb_data_idle", wb_data, 64'd0);

    // 2. Load extension
    load_case("lb", 64'h80, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    load_case("lbu", 64'h80, 2'd0, 1'b1, 64'h80);
    load_case("lh", 64'h8000, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8000);
    load_case("lhu", 64'hFFFF_8000, 2'd1, 1'b1, 64'h8000);
    load_case("lw", 64'h1_8000_0000, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000);
    load_case("lwu", 64'hFFFF_FFFF_8000_0000, 2'd2, 1'b1, 64'h8000_0000);
    load_case("ld", 64'h8123_4567_89AB_CDEF, 2'd3, 1'b0, 64'h8123_4567_89AB_CDEF);
    check("load.cnt", retire_cnt, 64'd8);

    // 3. x0 write suppressed but retires
    drive(64'h8000_0200, 32'h0000_0013, 1'b1, 5'd0, 2'd0, 64'h55, 64'h0, 2'd0, 1'b0, 64'h0);
    step();
    idle();
    check("x0.wb_rd_ena", 64'(wb_rd_ena), 64'd0);
    check("x0.fwd_valid", 64'(fwd_valid), 64'd0);
    check("x0.commit_valid", 64'(commit_valid), 64'd1);
    step();
    check("x0.cnt", retire_cnt, 64'd9);

    // 4. Back-to-back ALU, CSR, PC+4 from a clean counter
    do_reset();
    drive(64'h8000_0000, 32'h0000_0013, 1'b1, 5'd1, 2'd0, 64'hA1, 64'h0, 2'd0, 1'b0, 64'h0);
    step();
    drive(64'h8000_0004, 32'h3000_2073, 1'b1, 5'd2, 2'd2, 64'h0, 64'h0, 2'd0, 1'b0, 64'hC5);
    check("b2b1.commit", 64'(commit_valid), 64'd1);
    check("b2b1.data", wb_data, 64'hA1);
    step();
    drive(64'h8000_0008, 32'h0000_00EF, 1'b1, 5'd3, 2'd3, 64'h0, 64'h0, 2'd0, 1'b0, 64'h0);
    check("b2b2.commit", 64'(commit_valid), 64'd1);
    check("b2b2.data", wb_data, 64'hC5);
    check("b2b2.addr", 64'(wb_rd_addr), 64'd2);
    step();
    idle();
    check("b2b3.commit", 64'(commit_valid), 64'd1);
    check("b2b3.pc", commit_pc, 64'h8000_0008);
    check("b2b3.data", wb_data, 64'h8000_000C);
    check("b2b3.cnt_during", retire_cnt, 64'd2);
    step();
    check("b2b.cnt", retire_cnt, 64'd3);

    // 6. Flush
    drive(64'h8000_0300, 32'h0000_0013, 1'b1, 5'd7, 2'd0, 64'h77, 64'h0, 2'd0, 1'b0, 64'h0);
    flush = 1'b1;
    step();
    idle();
    check("flush.commit", 64'(commit_valid), 64'd0);
    step();
    check("flush.cnt", retire_cnt, 64'd3);
    drive(64'h8000_0304, 32'h0000_0013, 1'b1, 5'd8, 2'd0, 64'h88, 64'h0, 2'd0, 1'b0, 64'h0);
    step();
    drive(64'h8000_0308, 32'h0000_0013, 1'b1, 5'd9, 2'd0, 64'h99, 64'h0, 2'd0, 1'b0, 64'h0);
    flush = 1'b1;
    check("flushheld.commit", 64'(commit_valid), 64'd1);
    check("flushheld.pc", commit_pc, 64'h8000_0304);
    step();
    idle();
    check("flushheld.next", 64'(commit_valid), 64'd0);
    check("flushheld.cnt", retire_cnt, 64'd4);

    // rst mid-commit discards the entry
    drive(64'h8000_0400, 32'h0000_0013, 1'b1, 5'd4, 2'd0, 64'h44, 64'h0, 2'd0, 1'b0, 64'h0);
    step();
    idle();
    check("midrst.commit_before", 64'(commit_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");

    // 5. EBREAK halts; younger transfer held on in_valid is refused
    drive(64'h8000_0010, 32'h0010_0073, 1'b0, 5'd0, 2'd0, 64'h0, 64'h0, 2'd0, 1'b0, 64'h0);
    check("ebreak.ready_before", 64'(in_ready), 64'd1);
    step();
    drive(64'h8000_0014, 32'h0000_0013, 1'b1, 5'd10, 2'd0, 64'hBAD, 64'h0, 2'd0, 1'b0, 64'h0);
    check("ebreak.halt", 64'(halt), 64'd1);
    check("ebreak.halt_pc", halt_pc, 64'h8000_0010);
    check("ebreak.commit", 64'(commit_valid), 64'd1);
    check("ebreak.inst", 64'(commit_inst), 64'h0010_0073);
    check("ebreak.ready", 64'(in_ready), 64'd0);
    step();
    check("halted.commit", 64'(commit_valid), 64'd0);
    check("halted.cnt", retire_cnt, 64'd1);
    step();
    check("halted.commit2", 64'(commit_valid), 64'd0);
    check("halted.halt", 64'(halt), 64'd1);
    check("halted.wb_rd_ena", 64'(wb_rd_ena), 64'd0);
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    check_all_zero("halt_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
